// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch router.
package fetch_pkg;

  localparam int MAX_REGIONS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_UNMAPPED   = 2'b01,
    ERR_MISALIGNED = 2'b10
  } fetch_err_e;

endpackage

// File: rtl/memory_mapping_pkg.sv
// Address map of the instruction-capable memories and the default
// region tables used by the fetch router.
package memory_mapping;

  localparam logic [31:0] INST_ROM_BEGIN = 32'h0000_0000;
  localparam logic [31:0] INST_ROM_END   = 32'h0000_4000;
  localparam logic [31:0] DATA_RAM_BEGIN = 32'h1000_0000;
  localparam logic [31:0] DATA_RAM_END   = 32'h1001_0000;

  localparam int DEFAULT_N_REG = 2;

  localparam logic [31:0] DEFAULT_REG_BASE [DEFAULT_N_REG] = '{INST_ROM_BEGIN, DATA_RAM_BEGIN};
  localparam logic [31:0] DEFAULT_REG_END  [DEFAULT_N_REG] = '{INST_ROM_END,   DATA_RAM_END};
  localparam logic [3:0]  DEFAULT_REG_WAIT [DEFAULT_N_REG] = '{4'd0, 4'd0};

endpackage

// File: rtl/inst_fetch_router_decoder.sv
// Combinational window decoder: finds the lowest-index region whose
// [base, end) window contains the address, and flags misalignment.
module addr_region_decoder
  import memory_mapping::*;
#(
  parameter int N_REG  = 2,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = (N_REG > 1) ? $clog2(N_REG) : 1,
  parameter logic [ADDR_W-1:0] REG_BASE [N_REG] = DEFAULT_REG_BASE,
  parameter logic [ADDR_W-1:0] REG_END  [N_REG] = DEFAULT_REG_END
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              misaligned
);

  // Scan from the top index down so the lowest matching region wins overlaps.
  always_comb begin
    logic in_win;
    hit        = 1'b0;
    idx        = '0;
    in_win     = 1'b0;
    misaligned = (addr[1:0] != 2'b00);
    for (int k = N_REG - 1; k >= 0; k--) begin
      in_win = (addr >= REG_BASE[k]) && (addr < REG_END[k]);
      hit    = hit | in_win;
      idx    = in_win ? IDX_W'(k) : idx;
    end
  end

endmodule

// File: rtl/inst_fetch_router.sv
// Instruction fetch router: decodes the fetch address to a memory region,
// issues a one-cycle read strobe, waits the region latency and returns the
// word (or an error code) through a valid/ready response.
module inst_fetch_router
  import memory_mapping::*;
  import fetch_pkg::*;
#(
  parameter int N_REG  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] REG_BASE [N_REG] = DEFAULT_REG_BASE,
  parameter logic [ADDR_W-1:0] REG_END  [N_REG] = DEFAULT_REG_END,
  parameter logic [3:0]        REG_WAIT [N_REG] = DEFAULT_REG_WAIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [1:0]                   rsp_err,
  output logic [N_REG-1:0]             mem_rd,
  output logic [N_REG-1:0][ADDR_W-1:0] mem_addr,
  input  logic [N_REG-1:0][DATA_W-1:0] mem_data
);

  localparam int IDX_W = (N_REG > 1) ? $clog2(N_REG) : 1;

  fetch_state_e      state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  fetch_err_e        err_q, err_d;

  logic              dec_hit;
  logic              dec_mis;
  logic [IDX_W-1:0]  dec_idx;
  logic              accept;
  logic [ADDR_W-1:0] cur_addr;

  addr_region_decoder #(
    .N_REG    (N_REG),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .REG_BASE (REG_BASE),
    .REG_END  (REG_END)
  ) u_dec (
    .addr       (req_addr),
    .hit        (dec_hit),
    .idx        (dec_idx),
    .misaligned (dec_mis)
  );

  // Requests are taken when idle, or when the pending response retires this cycle.
  always_comb begin
    req_ready = 1'b0;
    if (!rst && !flush && (state_q == ST_IDLE || (state_q == ST_RESP && rsp_ready))) begin
      req_ready = 1'b1;
    end else begin
      req_ready = 1'b0;
    end
  end

  assign accept = req_valid && req_ready;

  // Read strobe in the accept cycle only; offsets follow the live address then the latched one.
  always_comb begin
    mem_rd   = '0;
    cur_addr = addr_q;
    if (accept) begin
      cur_addr = req_addr;
      if (dec_hit && !dec_mis) begin
        mem_rd[dec_idx] = 1'b1;
      end else begin
        mem_rd = '0;
      end
    end else begin
      cur_addr = addr_q;
    end
    for (int k = 0; k < N_REG; k++) begin
      mem_addr[k] = cur_addr - REG_BASE[k];
    end
  end

  // Next-state and datapath update for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept) begin
      addr_d = req_addr;
      if (dec_mis) begin
        state_d = ST_RESP;
        data_d  = '0;
        err_d   = ERR_MISALIGNED;
      end else if (dec_hit) begin
        state_d = ST_WAIT;
        sel_d   = dec_idx;
        cnt_d   = REG_WAIT[dec_idx];
      end else begin
        state_d = ST_RESP;
        data_d  = '0;
        err_d   = ERR_UNMAPPED;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_WAIT: begin
          if (flush) begin
            state_d = ST_IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            data_d  = mem_data[sel_q];
            err_d   = ERR_OK;
            state_d = ST_RESP;
          end
        end
        ST_RESP: begin
          if (flush || rsp_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RESP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_inst_fetch_router.sv
// Self-checking bench for inst_fetch_router: directed vector table,
// hand-written multi-cycle corner cases, and a randomized phase checked
// against a transaction-level model of the fetch protocol.
module tb_inst_fetch_router;
  import memory_mapping::*;

  localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;
  localparam logic [3:0]  WAITS [2] = '{4'd0, 4'd2};
  localparam logic [31:0] BASES [2] = '{INST_ROM_BEGIN, DATA_RAM_BEGIN};
  localparam logic [31:0] ENDS  [2] = '{INST_ROM_END, DATA_RAM_END};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [31:0]       req_addr = 32'd0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_err;
  logic [1:0]        mem_rd;
  logic [1:0][31:0]  mem_addr;
  logic [1:0][31:0]  mem_data;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int cd [2] = '{0, 0};
  logic [31:0] pend [2];

  inst_fetch_router #(
    .N_REG    (2),
    .ADDR_W   (32),
    .DATA_W   (32),
    .REG_BASE (BASES),
    .REG_END  (ENDS),
    .REG_WAIT (WAITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] content(input int k, input logic [31:0] off);
    return 32'h1357_0000 + (32'(k) << 28) + off;
  endfunction

  // Memory model: data is garbage until WAITS[k] edges after the strobe edge.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_rd[k]) begin
        if (WAITS[k] == 4'd0) begin
          mem_data[k] <= content(k, mem_addr[k]);
          cd[k] <= 0;
        end else begin
          mem_data[k] <= GARBAGE;
          cd[k] <= int'(WAITS[k]);
          pend[k] <= mem_addr[k];
        end
      end else if (cd[k] > 0) begin
        cd[k] <= cd[k] - 1;
        if (cd[k] == 1) mem_data[k] <= content(k, pend[k]);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference decode straight from the address-map rules.
  task automatic ref_decode(input logic [31:0] a, output int k, output logic [1:0] err, output int lat);
    int found;
    found = -1;
    for (int i = 0; i < 2; i++)
      if (found < 0 && a >= BASES[i] && a < ENDS[i]) found = i;
    k = (found < 0) ? 0 : found;
    if (a[1:0] != 2'b00) begin err = 2'b10; lat = 1; end
    else if (found < 0) begin err = 2'b01; lat = 1; end
    else begin err = 2'b00; lat = 2 + int'(WAITS[found]); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0: a = INST_ROM_BEGIN + ($urandom_range(0, 32'h0FFF) << 2);
      1: a = DATA_RAM_BEGIN + ($urandom_range(0, 32'h3FFF) << 2);
      2: a = INST_ROM_BEGIN + ($urandom_range(0, 32'h0FFF) << 2) + $urandom_range(1, 3);
      3: a = 32'h2000_0000 + ($urandom_range(0, 32'hFFFF) << 2);
      4: a = ($urandom_range(0, 1) == 0) ? INST_ROM_END - 32'd4 : INST_ROM_END;
      default: a = ($urandom_range(0, 1) == 0) ? DATA_RAM_END - 32'd4 : DATA_RAM_END;
    endcase
    return a;
  endfunction

  // Called at +2 in the cycle after accept; waits for rsp_valid with a bound.
  task automatic wait_rsp(input string nm, input int lat, input logic [31:0] d, input logic [1:0] e,
                          input int hold_k, input logic [31:0] hold_off);
    int n;
    n = 1;
    while (!rsp_valid && n < 40) begin
      if (hold_k >= 0) chk({nm, "_mem_addr_hold"}, mem_addr[hold_k], hold_off);
      chk({nm, "_mem_rd_quiet"}, mem_rd, 2'b00);
      @(posedge clk); #2;
      n++;
    end
    chk({nm, "_latency"}, n, lat);
    chk({nm, "_data"}, rsp_data, d);
    chk({nm, "_err"}, rsp_err, e);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic [1:0]  rd;
    int          ridx;
    logic [31:0] off;
    logic [1:0]  err;
    int          lat;
  } vec_t;

  task automatic do_fetch(input vec_t v);
    logic [31:0] d;
    d = (v.err == 2'b00) ? content(v.ridx, v.off) : 32'd0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = v.addr; rsp_ready = 1'b1; flush = 1'b0;
    #1;
    chk({v.nm, "_req_ready"}, req_ready, 1'b1);
    chk({v.nm, "_mem_rd"}, mem_rd, v.rd);
    if (v.rd != 2'b00) chk({v.nm, "_mem_addr"}, mem_addr[v.ridx], v.off);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~v.addr;
    #1;
    wait_rsp(v.nm, v.lat, d, v.err, (v.rd != 2'b00) ? v.ridx : -1, v.off);
    @(posedge clk); #2;
    chk({v.nm, "_retire"}, rsp_valid, 1'b0);
  endtask

  vec_t vecs [10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, lat;
    logic [1:0] e;
    bit out_v;
    int out_rdy;
    logic [31:0] out_data;
    logic [1:0] out_err;
    bit exp_rv, exp_rr;
    logic [1:0] exp_rd;

    vecs[0] = '{"rom8",     INST_ROM_BEGIN + 32'd8,      2'b01, 0, 32'd8,      2'b00, 2};
    vecs[1] = '{"ram4",     DATA_RAM_BEGIN + 32'd4,      2'b10, 1, 32'd4,      2'b00, 4};
    vecs[2] = '{"unmapped", 32'hFFFF_FFF0,               2'b00, 0, 32'd0,      2'b01, 1};
    vecs[3] = '{"misalign", INST_ROM_BEGIN + 32'd2,      2'b00, 0, 32'd0,      2'b10, 1};
    vecs[4] = '{"rom_last", INST_ROM_END - 32'd4,        2'b01, 0, 32'h3FFC,   2'b00, 2};
    vecs[5] = '{"rom_end",  INST_ROM_END,                2'b00, 0, 32'd0,      2'b01, 1};
    vecs[6] = '{"ram_last", DATA_RAM_END - 32'd4,        2'b10, 1, 32'hFFFC,   2'b00, 4};
    vecs[7] = '{"ram_pre",  DATA_RAM_BEGIN - 32'd4,      2'b00, 0, 32'd0,      2'b01, 1};
    vecs[8] = '{"ram_mis",  DATA_RAM_BEGIN + 32'h103,    2'b00, 0, 32'd0,      2'b10, 1};
    vecs[9] = '{"ram_end",  DATA_RAM_END,                2'b00, 0, 32'd0,      2'b01, 1};

    // Reset behaviour: no acceptance and no strobe while rst is high.
    req_valid = 1'b1; req_addr = INST_ROM_BEGIN + 32'd8;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_mem_rd", mem_rd, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", rsp_err, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;

    foreach (vecs[i]) do_fetch(vecs[i]);

    // Backpressure then same-cycle accept on handshake.
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = INST_ROM_BEGIN + 32'd12;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    chk("bp_rsp_valid", rsp_valid, 1'b1);
    req_valid = 1'b1; req_addr = DATA_RAM_BEGIN + 32'd8;
    repeat (5) begin
      @(posedge clk); #2;
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, content(0, 32'd12));
      chk("bp_hold_err", rsp_err, 2'b00);
      chk("bp_req_ready", req_ready, 1'b0);
      chk("bp_mem_rd", mem_rd, 2'b00);
    end
    rsp_ready = 1'b1;
    #1;
    chk("b2b_req_ready", req_ready, 1'b1);
    chk("b2b_mem_rd", mem_rd, 2'b10);
    chk("b2b_mem_addr", mem_addr[1], 32'd8);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    chk("b2b_drop", rsp_valid, 1'b0);
    wait_rsp("b2b", 4, content(1, 32'd8), 2'b00, 1, 32'd8);
    @(posedge clk); #2;

    // Flush in IDLE only blocks acceptance.
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_addr = INST_ROM_BEGIN + 32'd8;
    #1;
    chk("flush_idle_ready", req_ready, 1'b0);
    chk("flush_idle_rd", mem_rd, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush_idle_valid", rsp_valid, 1'b0);

    // Flush in WAIT discards the fetch; next RAM fetch ignores the stale read.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = DATA_RAM_BEGIN + 32'd16;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_wait_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_wait_valid", rsp_valid, 1'b0);
    chk("flush_wait_idle", req_ready, 1'b1);
    do_fetch('{"after_flush", DATA_RAM_BEGIN + 32'd20, 2'b10, 1, 32'd20, 2'b00, 4});

    // Flush together with rsp_ready in RESP: flush wins, nothing accepted.
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = INST_ROM_BEGIN + 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = INST_ROM_BEGIN + 32'd8;
    #1;
    chk("fr_valid", rsp_valid, 1'b1);
    chk("fr_req_ready", req_ready, 1'b0);
    chk("fr_mem_rd", mem_rd, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("fr_dropped", rsp_valid, 1'b0);
    chk("fr_idle", req_ready, 1'b1);

    // Reset mid-WAIT abandons the read.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = DATA_RAM_BEGIN + 32'd24;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    #1;
    chk("rstw_ready", req_ready, 1'b0);
    @(posedge clk); #2;
    chk("rstw_valid", rsp_valid, 1'b0);
    chk("rstw_data", rsp_data, 32'd0);
    chk("rstw_ready2", req_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
      chk("rstw_quiet", rsp_valid, 1'b0);
    end
    do_fetch(vecs[1]);

    // Randomized traffic against a transaction-level model.
    out_v = 1'b0; out_rdy = 0; out_data = 32'd0; out_err = 2'b00;
    repeat (600) begin
      @(posedge clk); #1;
      req_valid = ($urandom_range(0, 2) != 0);
      req_addr  = rand_addr();
      rsp_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      exp_rv = out_v && (cyc >= out_rdy);
      chk("rnd_rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rnd_rsp_data", rsp_data, out_data);
        chk("rnd_rsp_err", rsp_err, out_err);
      end
      exp_rr = !flush && (!out_v || (exp_rv && rsp_ready));
      chk("rnd_req_ready", req_ready, exp_rr);
      ref_decode(req_addr, k, e, lat);
      exp_rd = (req_valid && exp_rr && e == 2'b00) ? (2'b01 << k) : 2'b00;
      chk("rnd_mem_rd", mem_rd, exp_rd);
      if (exp_rd != 2'b00) chk("rnd_mem_addr", mem_addr[k], req_addr - BASES[k]);
      if (flush || (exp_rv && rsp_ready)) out_v = 1'b0;
      if (req_valid && exp_rr) begin
        out_v    = 1'b1;
        out_rdy  = cyc + lat;
        out_err  = e;
        out_data = (e == 2'b00) ? content(k, req_addr - BASES[k]) : 32'd0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
